// File: rtl/fifo_thresh.sv
// Single-clock FIFO with programmable almost-empty/almost-full thresholds.
// Ports: clk, reset (async low), wr_en/data_in, rd_en, thr_low/thr_high in;
//   data_out/valid_out (1-cycle read), empty, full, almost_*, error, count out.
module fifo_thresh #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [4:0]            thr_low,
  input  logic [4:0]            thr_high,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = (ADDR_WIDTH + 1 > 5) ? ADDR_WIDTH + 1 : 5;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic          rd_acc;
  logic          wr_acc;
  logic [CW-1:0] cnt_ext;
  logic [CW-1:0] lo_ext;
  logic [CW-1:0] hi_ext;

  // Flags come from the registered count so they never glitch on inputs
  // other than the thresholds, which act in the same cycle.
  assign cnt_ext      = CW'(count_q);
  assign lo_ext       = CW'(thr_low);
  assign hi_ext       = CW'(thr_high);
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (cnt_ext <= lo_ext);
  assign almost_full  = (cnt_ext >= hi_ext);

  // A read frees a slot this edge, so a write into a full FIFO is allowed
  // alongside it. A read from empty never falls through a same-edge write.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = rd_acc;
    error_d    = error_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case (1'b1)
      (wr_acc && !rd_acc): count_d = count_q + 1'b1;
      (rd_acc && !wr_acc): count_d = count_q - 1'b1;
      default:             count_d = count_q;
    endcase

    if ((wr_en && !wr_acc) || (rd_en && empty)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign error     = error_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fifo_thresh.sv
// Directed plus randomized bench for fifo_thresh against a queue model.
// Checks every output each cycle; prints one summary line.
module tb_fifo_thresh;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [5:0] data_in;
  logic       rd_en;
  logic [4:0] thr_low;
  logic [4:0] thr_high;
  logic [5:0] data_out;
  logic       valid_out;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       error;
  logic [4:0] count;

  int tests;
  int fails;

  int m_q[$];
  int m_dout;
  bit m_valid;
  bit m_err;

  fifo_thresh dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .thr_low      (thr_low),
    .thr_high     (thr_high),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .error        (error),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout  = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // Compare every output against the model's view of the FIFO.
  task automatic chk_all(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".count"}, int'(count), n);
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".full"}, int'(full), int'(n == 16));
    chk({tag, ".aempty"}, int'(almost_empty), int'(n <= int'(thr_low)));
    chk({tag, ".afull"}, int'(almost_full), int'(n >= int'(thr_high)));
    chk({tag, ".error"}, int'(error), int'(m_err));
    chk({tag, ".valid"}, int'(valid_out), int'(m_valid));
    chk({tag, ".dout"}, int'(data_out), m_dout);
  endtask

  // Drive one clock with the given request, advance model, check outputs.
  task automatic cyc(input bit we, input int d, input bit re,
                     input string tag);
    int  n;
    bit  rd_ok;
    bit  wr_ok;
    wr_en   = we;
    rd_en   = re;
    data_in = 6'(d);
    @(posedge clk);
    n     = m_q.size();
    rd_ok = re && (n > 0);
    wr_ok = we && ((n < 16) || rd_ok);
    if ((we && !wr_ok) || (re && n == 0)) m_err = 1'b1;
    m_valid = rd_ok;
    if (rd_ok) m_dout = m_q.pop_front();
    if (wr_ok) m_q.push_back(d & 6'h3f);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = '0;
    thr_low  = 5'd2;
    thr_high = 5'd14;
    model_reset();

    // Reset and idle.
    #12;
    chk_all("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b0, 0, 1'b0, "idle");

    // Five writes, five reads; almost_empty follows the count.
    for (int i = 1; i <= 5; i++) cyc(1'b1, i, 1'b0, "wr5");
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 0, 1'b1, "rd5");
      chk("rd5.data", int'(data_out), i);
    end

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) cyc(1'b1, 6'h20 + i, 1'b0, "fill");
    chk("fill.full", int'(full), 1);
    cyc(1'b1, 6'h3f, 1'b0, "ovf");
    chk("ovf.err", int'(error), 1);
    chk("ovf.cnt", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 0, 1'b1, "drain");
      chk("drain.data", int'(data_out), 6'h20 + i);
    end

    // Full with simultaneous read/write, pointers wrap past 15.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, i, 1'b0, "fill2");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 6'h30 + i, 1'b1, "rw_full");
      chk("rw_full.data", int'(data_out), i);
    end
    chk("rw_full.err", int'(error), 0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 1'b1, "drain2");
    chk("drain2.last", int'(data_out), 6'h32);

    // Read on empty with concurrent write: no fall-through.
    do_reset();
    cyc(1'b1, 6'h2a, 1'b1, "emp_rw");
    chk("emp_rw.valid", int'(valid_out), 0);
    chk("emp_rw.err", int'(error), 1);
    cyc(1'b0, 0, 1'b1, "emp_rd");
    chk("emp_rd.data", int'(data_out), 6'h2a);

    // Async reset mid-cycle with thr_high=0.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, i + 1, 1'b0, "fill7");
    thr_high = 5'd0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk_all("async");
    chk("async.af", int'(almost_full), 1);
    #1;
    reset = 1'b1;
    cyc(1'b1, 6'h11, 1'b0, "post_wr");
    cyc(1'b0, 0, 1'b1, "post_rd");
    chk("post_rd.data", int'(data_out), 6'h11);
    thr_high = 5'd14;

    // Randomized segments with random thresholds, including > DEPTH.
    for (int s = 0; s < 8; s++) begin
      int pw;
      int pr;
      do_reset();
      thr_low  = 5'($urandom_range(0, 31));
      thr_high = 5'($urandom_range(0, 31));
      pw = $urandom_range(20, 80);
      pr = $urandom_range(20, 80);
      for (int c = 0; c < 150; c++) begin
        bit we;
        bit re;
        we = ($urandom_range(0, 99) < pw);
        re = ($urandom_range(0, 99) < pr);
        cyc(we, $urandom_range(0, 63), re, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
